// File: rtl/icb_arb_2to1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icb_arb_2to1_pkg : shared ICB widths, command bundle type, log2 helper      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package icb_arb_2to1_pkg;

  localparam int ICB_ADDR_W = 32;
  localparam int ICB_DATA_W = 32;
  localparam int ICB_MASK_W = 4;
  localparam int SRC_ID_W   = 1;

  typedef struct packed {
    logic [ICB_ADDR_W-1:0] addr;
    logic                  read;
    logic [ICB_DATA_W-1:0] wdata;
    logic [ICB_MASK_W-1:0] wmask;
  } icb_cmd_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icb_arb_src_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icb_arb_src_fifo : register FIFO of source ids for in-order response routing|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module icb_arb_src_fifo
  import icb_arb_2to1_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SRC_ID_W,
  parameter int CNT_W = clogb2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? clogb2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // full/empty come from start-of-cycle occupancy, so a pop never frees room for a same-cycle push
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= inc_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= inc_ptr(r_rd_ptr);
      if (w_push & ~w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop & ~w_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/icb_arb_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icb_arb_2to1 : merges instruction and data ICB masters onto one SRAM port   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module icb_arb_2to1
  import icb_arb_2to1_pkg::*;
#(
  parameter int    OUTSTANDING_N    = 4,
  parameter string FIXED_PRIORITY   = "false",
  parameter int    SIMULATION_DELAY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ICB_ADDR_W-1:0]          s0_icb_cmd_addr,
  input  logic                           s0_icb_cmd_read,
  input  logic [ICB_DATA_W-1:0]          s0_icb_cmd_wdata,
  input  logic [ICB_MASK_W-1:0]          s0_icb_cmd_wmask,
  input  logic                           s0_icb_cmd_valid,
  output logic                           s0_icb_cmd_ready,
  output logic [ICB_DATA_W-1:0]          s0_icb_rsp_rdata,
  output logic                           s0_icb_rsp_err,
  output logic                           s0_icb_rsp_valid,
  input  logic                           s0_icb_rsp_ready,
  input  logic [ICB_ADDR_W-1:0]          s1_icb_cmd_addr,
  input  logic                           s1_icb_cmd_read,
  input  logic [ICB_DATA_W-1:0]          s1_icb_cmd_wdata,
  input  logic [ICB_MASK_W-1:0]          s1_icb_cmd_wmask,
  input  logic                           s1_icb_cmd_valid,
  output logic                           s1_icb_cmd_ready,
  output logic [ICB_DATA_W-1:0]          s1_icb_rsp_rdata,
  output logic                           s1_icb_rsp_err,
  output logic                           s1_icb_rsp_valid,
  input  logic                           s1_icb_rsp_ready,
  output logic [ICB_ADDR_W-1:0]          m_icb_cmd_addr,
  output logic                           m_icb_cmd_read,
  output logic [ICB_DATA_W-1:0]          m_icb_cmd_wdata,
  output logic [ICB_MASK_W-1:0]          m_icb_cmd_wmask,
  output logic                           m_icb_cmd_valid,
  input  logic                           m_icb_cmd_ready,
  input  logic [ICB_DATA_W-1:0]          m_icb_rsp_rdata,
  input  logic                           m_icb_rsp_err,
  input  logic                           m_icb_rsp_valid,
  output logic                           m_icb_rsp_ready,
  output logic [clogb2(OUTSTANDING_N):0] outstanding_cnt,
  output logic                           rsp_orphan_err
);

  localparam bit c_fixed_prio = (FIXED_PRIORITY == "true");

  if (OUTSTANDING_N < 1 || OUTSTANDING_N > 16 ||
      (OUTSTANDING_N & (OUTSTANDING_N - 1)) != 0 || SIMULATION_DELAY < 0) begin : g_param_check
    $error("icb_arb_2to1: illegal parameter value");
  end

  icb_cmd_t            w_s0_cmd;
  icb_cmd_t            w_s1_cmd;
  icb_cmd_t            w_m_cmd;
  logic [SRC_ID_W-1:0] w_sel;
  logic [SRC_ID_W-1:0] w_head;
  logic                w_sel_valid;
  logic                w_full;
  logic                w_empty;
  logic                w_cmd_hs;
  logic                w_pop;
  logic                r_lock;
  logic [SRC_ID_W-1:0] r_lock_src;
  logic [SRC_ID_W-1:0] r_last_grant;
  logic                r_orphan;

  // A locked grant keeps the command fields stable while the slave backpressures
  always_comb begin
    w_sel = '0;
    if (r_lock)                                     w_sel = r_lock_src;
    else if (s0_icb_cmd_valid & s1_icb_cmd_valid)   w_sel = c_fixed_prio ? '0 : ~r_last_grant;
    else if (s1_icb_cmd_valid)                      w_sel = SRC_ID_W'(1);
  end

  assign w_s0_cmd = {s0_icb_cmd_addr, s0_icb_cmd_read, s0_icb_cmd_wdata, s0_icb_cmd_wmask};
  assign w_s1_cmd = {s1_icb_cmd_addr, s1_icb_cmd_read, s1_icb_cmd_wdata, s1_icb_cmd_wmask};
  assign w_m_cmd     = w_sel[0] ? w_s1_cmd : w_s0_cmd;
  assign w_sel_valid = w_sel[0] ? s1_icb_cmd_valid : s0_icb_cmd_valid;

  assign m_icb_cmd_addr   = w_m_cmd.addr;
  assign m_icb_cmd_read   = w_m_cmd.read;
  assign m_icb_cmd_wdata  = w_m_cmd.wdata;
  assign m_icb_cmd_wmask  = w_m_cmd.wmask;
  assign m_icb_cmd_valid  = w_sel_valid & ~w_full;
  assign s0_icb_cmd_ready = ~w_sel[0] & m_icb_cmd_ready & ~w_full;
  assign s1_icb_cmd_ready =  w_sel[0] & m_icb_cmd_ready & ~w_full;
  assign w_cmd_hs         = m_icb_cmd_valid & m_icb_cmd_ready;

  // With nothing outstanding, responses are drained and flagged as orphans
  assign s0_icb_rsp_valid = ~w_empty & ~w_head[0] & m_icb_rsp_valid;
  assign s1_icb_rsp_valid = ~w_empty &  w_head[0] & m_icb_rsp_valid;
  assign m_icb_rsp_ready  = w_empty | (w_head[0] ? s1_icb_rsp_ready : s0_icb_rsp_ready);
  assign s0_icb_rsp_rdata = m_icb_rsp_rdata;
  assign s1_icb_rsp_rdata = m_icb_rsp_rdata;
  assign s0_icb_rsp_err   = m_icb_rsp_err;
  assign s1_icb_rsp_err   = m_icb_rsp_err;
  assign w_pop            = m_icb_rsp_valid & m_icb_rsp_ready & ~w_empty;
  assign rsp_orphan_err   = r_orphan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock       <= 1'b0;
      r_lock_src   <= '0;
      r_last_grant <= SRC_ID_W'(1);
      r_orphan     <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_lock       <= 1'b0;
        r_last_grant <= w_sel;
      end else if (m_icb_cmd_valid & ~r_lock) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_sel;
      end
      if (m_icb_rsp_valid & w_empty) r_orphan <= 1'b1;
    end
  end

  icb_arb_src_fifo #(
    .DEPTH (OUTSTANDING_N),
    .WIDTH (SRC_ID_W)
  ) u_src_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cmd_hs),
    .i_din   (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_icb_arb_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_icb_arb_2to1 : directed and random checks against a queue-based model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_icb_arb_2to1;
  import icb_arb_2to1_pkg::*;

  localparam int N  = 4;
  localparam int CW = clogb2(N) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
  logic        s0_read, s1_read, s0_valid, s1_valid, s0_rsp_ready, s1_rsp_ready;
  logic [3:0]  s0_wmask, s1_wmask;
  logic        s0_ready, s1_ready, s0_err, s1_err, s0_rvalid, s1_rvalid;
  logic [31:0] s0_rdata, s1_rdata;
  logic [31:0] m_addr, m_wdata, m_rsp_rdata;
  logic        m_read, m_valid, m_cmd_ready, m_rsp_err, m_rsp_valid, m_rsp_ready;
  logic [3:0]  m_wmask;
  logic [CW-1:0] cnt;
  logic        orphan;

  // fixed-priority instance, exercised only by the tie test
  logic        f_v0, f_v1, f_mready;
  logic        f_s0_ready, f_s1_ready, f_s0_err, f_s1_err, f_s0_rvalid, f_s1_rvalid;
  logic [31:0] f_s0_rdata, f_s1_rdata, f_m_addr, f_m_wdata;
  logic        f_m_read, f_m_valid, f_m_rsp_ready, f_orphan;
  logic [3:0]  f_m_wmask;
  logic [CW-1:0] f_cnt;

  icb_arb_2to1 #(.OUTSTANDING_N(N), .FIXED_PRIORITY("false"), .SIMULATION_DELAY(1)) dut (
    .clk(clk), .rst(rst),
    .s0_icb_cmd_addr(s0_addr), .s0_icb_cmd_read(s0_read), .s0_icb_cmd_wdata(s0_wdata),
    .s0_icb_cmd_wmask(s0_wmask), .s0_icb_cmd_valid(s0_valid), .s0_icb_cmd_ready(s0_ready),
    .s0_icb_rsp_rdata(s0_rdata), .s0_icb_rsp_err(s0_err), .s0_icb_rsp_valid(s0_rvalid),
    .s0_icb_rsp_ready(s0_rsp_ready),
    .s1_icb_cmd_addr(s1_addr), .s1_icb_cmd_read(s1_read), .s1_icb_cmd_wdata(s1_wdata),
    .s1_icb_cmd_wmask(s1_wmask), .s1_icb_cmd_valid(s1_valid), .s1_icb_cmd_ready(s1_ready),
    .s1_icb_rsp_rdata(s1_rdata), .s1_icb_rsp_err(s1_err), .s1_icb_rsp_valid(s1_rvalid),
    .s1_icb_rsp_ready(s1_rsp_ready),
    .m_icb_cmd_addr(m_addr), .m_icb_cmd_read(m_read), .m_icb_cmd_wdata(m_wdata),
    .m_icb_cmd_wmask(m_wmask), .m_icb_cmd_valid(m_valid), .m_icb_cmd_ready(m_cmd_ready),
    .m_icb_rsp_rdata(m_rsp_rdata), .m_icb_rsp_err(m_rsp_err), .m_icb_rsp_valid(m_rsp_valid),
    .m_icb_rsp_ready(m_rsp_ready), .outstanding_cnt(cnt), .rsp_orphan_err(orphan)
  );

  icb_arb_2to1 #(.OUTSTANDING_N(N), .FIXED_PRIORITY("true"), .SIMULATION_DELAY(1)) dut_fix (
    .clk(clk), .rst(rst),
    .s0_icb_cmd_addr(32'h0), .s0_icb_cmd_read(1'b1), .s0_icb_cmd_wdata(32'h0),
    .s0_icb_cmd_wmask(4'h0), .s0_icb_cmd_valid(f_v0), .s0_icb_cmd_ready(f_s0_ready),
    .s0_icb_rsp_rdata(f_s0_rdata), .s0_icb_rsp_err(f_s0_err), .s0_icb_rsp_valid(f_s0_rvalid),
    .s0_icb_rsp_ready(1'b1),
    .s1_icb_cmd_addr(32'h4), .s1_icb_cmd_read(1'b1), .s1_icb_cmd_wdata(32'h0),
    .s1_icb_cmd_wmask(4'h0), .s1_icb_cmd_valid(f_v1), .s1_icb_cmd_ready(f_s1_ready),
    .s1_icb_rsp_rdata(f_s1_rdata), .s1_icb_rsp_err(f_s1_err), .s1_icb_rsp_valid(f_s1_rvalid),
    .s1_icb_rsp_ready(1'b1),
    .m_icb_cmd_addr(f_m_addr), .m_icb_cmd_read(f_m_read), .m_icb_cmd_wdata(f_m_wdata),
    .m_icb_cmd_wmask(f_m_wmask), .m_icb_cmd_valid(f_m_valid), .m_icb_cmd_ready(f_mready),
    .m_icb_rsp_rdata(32'h0), .m_icb_rsp_err(1'b0), .m_icb_rsp_valid(1'b0),
    .m_icb_rsp_ready(f_m_rsp_ready), .outstanding_cnt(f_cnt), .rsp_orphan_err(f_orphan)
  );

  // Reference model: queue of masters awaiting responses, the master the arbiter is
  // committed to after a refused offer, the master served last, and the orphan flag.
  int q[$];
  bit held;
  int held_src;
  int last_served;
  bit m_orphan;
  int e_sel;
  bit e_mvalid, e_cmd_hs, e_rsp_hs, hs0, hs1;
  int n_cmp, n_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held = 0; held_src = 0; last_served = 1; m_orphan = 0;
    hs0 = 0; hs1 = 0; e_cmd_hs = 0; e_rsp_hs = 0; e_mvalid = 0; e_sel = 0;
  endtask

  task automatic settle();
    bit full, empty, any, k_ready;
    int k;
    @(negedge clk);
    full  = (q.size() == N);
    empty = (q.size() == 0);
    if (held)                    e_sel = held_src;
    else if (s0_valid && s1_valid) e_sel = 1 - last_served;
    else if (s1_valid)           e_sel = 1;
    else                         e_sel = 0;
    any      = held || s0_valid || s1_valid;
    e_mvalid = any && ((e_sel == 1) ? s1_valid : s0_valid) && !full;
    chk("m_cmd_valid", m_valid, e_mvalid);
    if (any) begin
      chk("s0_cmd_ready", s0_ready, (e_sel == 0) && m_cmd_ready && !full);
      chk("s1_cmd_ready", s1_ready, (e_sel == 1) && m_cmd_ready && !full);
    end
    if (e_mvalid) begin
      chk("m_cmd_addr",  m_addr,  (e_sel == 1) ? s1_addr  : s0_addr);
      chk("m_cmd_read",  m_read,  (e_sel == 1) ? s1_read  : s0_read);
      chk("m_cmd_wdata", m_wdata, (e_sel == 1) ? s1_wdata : s0_wdata);
      chk("m_cmd_wmask", m_wmask, (e_sel == 1) ? s1_wmask : s0_wmask);
    end
    if (empty) begin
      chk("m_rsp_ready_drain", m_rsp_ready, 1'b1);
      chk("s0_rsp_valid_idle", s0_rvalid, 1'b0);
      chk("s1_rsp_valid_idle", s1_rvalid, 1'b0);
      e_rsp_hs = m_rsp_valid;
    end else begin
      k = q[0];
      k_ready = (k == 1) ? s1_rsp_ready : s0_rsp_ready;
      chk("s0_rsp_valid", s0_rvalid, (k == 0) && m_rsp_valid);
      chk("s1_rsp_valid", s1_rvalid, (k == 1) && m_rsp_valid);
      chk("m_rsp_ready", m_rsp_ready, k_ready);
      e_rsp_hs = m_rsp_valid && k_ready;
    end
    chk("s0_rsp_rdata", s0_rdata, m_rsp_rdata);
    chk("s1_rsp_rdata", s1_rdata, m_rsp_rdata);
    chk("s0_rsp_err", s0_err, m_rsp_err);
    chk("s1_rsp_err", s1_err, m_rsp_err);
    chk("outstanding_cnt", cnt, q.size());
    chk("rsp_orphan_err", orphan, m_orphan);
    e_cmd_hs = e_mvalid && m_cmd_ready;
    hs0 = e_cmd_hs && (e_sel == 0);
    hs1 = e_cmd_hs && (e_sel == 1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (e_rsp_hs) begin
        if (q.size() == 0) m_orphan = 1;
        else void'(q.pop_front());
      end
      if (e_cmd_hs) begin
        q.push_back(e_sel);
        last_served = e_sel;
        held = 0;
      end else if (e_mvalid && !held) begin
        held = 1;
        held_src = e_sel;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1;
    s0_addr = 0; s0_wdata = 0; s0_read = 0; s0_wmask = 0; s0_valid = 0; s0_rsp_ready = 0;
    s1_addr = 0; s1_wdata = 0; s1_read = 0; s1_wmask = 0; s1_valid = 0; s1_rsp_ready = 0;
    m_cmd_ready = 0; m_rsp_rdata = 0; m_rsp_err = 0; m_rsp_valid = 0;
    f_v0 = 0; f_v1 = 0; f_mready = 0;
    @(posedge clk); #1;
    model_reset();

    // reset state
    settle();
    chk("rst_cnt", cnt, 0);
    chk("rst_orphan", orphan, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s0_ready", s0_ready, 1'b0);
    chk("rst_s1_ready", s1_ready, 1'b0);
    chk("rst_s0_rvalid", s0_rvalid, 1'b0);
    chk("rst_s1_rvalid", s1_rvalid, 1'b0);
    tick();
    rst = 0;

    // single master read
    s0_addr = 32'h100; s0_read = 1; s0_valid = 1; m_cmd_ready = 1;
    s0_rsp_ready = 1; s1_rsp_ready = 1;
    settle();
    chk("single_addr", m_addr, 32'h100);
    chk("single_ready", s0_ready, 1'b1);
    tick();
    s0_valid = 0;
    chk("single_cnt1", cnt, 1);
    m_rsp_valid = 1; m_rsp_rdata = 32'hDEADBEEF; m_rsp_err = 0;
    settle();
    chk("single_rdata", s0_rdata, 32'hDEADBEEF);
    chk("single_s0_rvalid", s0_rvalid, 1'b1);
    chk("single_s1_rvalid", s1_rvalid, 1'b0);
    tick();
    m_rsp_valid = 0;
    chk("single_cnt0", cnt, 0);

    // tie: round-robin alternates, fixed priority always picks s0
    rst = 1; cyc(); rst = 0;
    s0_valid = 1; s1_valid = 1; s0_addr = 32'hA00; s1_addr = 32'hB00;
    s0_read = 1; s1_read = 0; s1_wdata = 32'h1234_5678; s1_wmask = 4'hF;
    f_v0 = 1; f_v1 = 1; f_mready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("tie_rr_s0", s0_ready, (i % 2) == 0);
      chk("tie_rr_s1", s1_ready, (i % 2) == 1);
      chk("tie_fix_s0", f_s0_ready, 1'b1);
      chk("tie_fix_s1", f_s1_ready, 1'b0);
      tick();
      if ((i % 2) == 0) s0_addr = s0_addr + 4; else s1_addr = s1_addr + 4;
    end
    s0_valid = 0; s1_valid = 0; f_v0 = 0; f_v1 = 0;
    chk("tie_cnt_full", cnt, 4);
    m_rsp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      m_rsp_rdata = $urandom; m_rsp_err = i[0];
      settle();
      chk("tie_rsp_route", s1_rvalid, (i % 2) == 1);
      tick();
    end
    m_rsp_valid = 0;

    // backpressure lock: s1 keeps the bus while s0 joins
    m_cmd_ready = 0; s1_valid = 1; s1_addr = 32'h200; s1_read = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin s0_valid = 1; s0_addr = 32'h300; s0_read = 1; end
      settle();
      chk("lock_addr", m_addr, 32'h200);
      tick();
    end
    m_cmd_ready = 1;
    settle();
    chk("lock_s1_first", s1_ready, 1'b1);
    chk("lock_s0_wait", s0_ready, 1'b0);
    tick();
    s1_valid = 0;
    settle();
    chk("lock_s0_next", s0_ready, 1'b1);
    chk("lock_s0_addr", m_addr, 32'h300);
    tick();
    s0_valid = 0;
    m_rsp_valid = 1; cyc(); cyc(); m_rsp_valid = 0;

    // full: 5th command waits for a response, then goes the cycle after
    s1_valid = 1; s1_read = 0; s1_wmask = 4'hF; s1_addr = 32'h400;
    for (int i = 0; i < 8; i++) begin
      m_rsp_valid = (i == 6);
      settle();
      chk("full_s1_ready", s1_ready, (i < 4) || (i == 7));
      tick();
      if ((i < 4) || (i == 7)) s1_addr = s1_addr + 4;
    end
    s1_valid = 0; m_rsp_valid = 0;
    chk("full_cnt", cnt, 4);
    m_rsp_valid = 1;
    for (int i = 0; i < 4; i++) cyc();
    m_rsp_valid = 0;

    // in-order routing of s0 read, s1 write, s0 read
    s0_valid = 1; s0_read = 1; s0_addr = 32'h500; cyc(); s0_valid = 0;
    s1_valid = 1; s1_read = 0; s1_wmask = 4'b0011; s1_addr = 32'h504; s1_wdata = 32'hCAFE0001;
    settle();
    chk("order_wmask", m_wmask, 4'b0011);
    tick();
    s1_valid = 0;
    s0_valid = 1; s0_addr = 32'h508; cyc(); s0_valid = 0;
    m_rsp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      m_rsp_err = (i == 1);
      settle();
      chk("order_s0_rvalid", s0_rvalid, i != 1);
      chk("order_s1_rvalid", s1_rvalid, i == 1);
      chk("order_err", (i == 1) ? s1_err : s0_err, i == 1);
      tick();
    end
    m_rsp_valid = 0; m_rsp_err = 0;

    // random traffic with legal masters and an in-order slave
    for (int c = 0; c < 400; c++) begin
      if (!s0_valid && $urandom_range(0, 1) == 1) begin
        s0_valid = 1; s0_addr = $urandom; s0_read = 1'($urandom_range(0, 1));
        s0_wdata = $urandom; s0_wmask = 4'($urandom);
      end
      if (!s1_valid && $urandom_range(0, 1) == 1) begin
        s1_valid = 1; s1_addr = $urandom; s1_read = 1'($urandom_range(0, 1));
        s1_wdata = $urandom; s1_wmask = 4'($urandom);
      end
      m_cmd_ready  = ($urandom_range(0, 3) != 0);
      m_rsp_valid  = (q.size() != 0) && ($urandom_range(0, 1) == 1);
      m_rsp_rdata  = $urandom;
      m_rsp_err    = 1'($urandom_range(0, 1));
      s0_rsp_ready = ($urandom_range(0, 3) != 0);
      s1_rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
      if (hs0) s0_valid = 0;
      if (hs1) s1_valid = 0;
    end
    m_cmd_ready = 1; s0_rsp_ready = 1; s1_rsp_ready = 1;
    for (int c = 0; c < 40; c++) begin
      if (!s0_valid && !s1_valid && q.size() == 0 && !held) break;
      m_rsp_valid = (q.size() != 0);
      cyc();
      if (hs0) s0_valid = 0;
      if (hs1) s1_valid = 0;
    end
    m_rsp_valid = 0;
    chk("drain_cnt", cnt, 0);

    // orphan response, then reset with two commands outstanding
    m_rsp_valid = 1;
    settle();
    chk("orphan_rsp_ready", m_rsp_ready, 1'b1);
    tick();
    m_rsp_valid = 0;
    chk("orphan_set", orphan, 1'b1);
    s0_valid = 1; s0_read = 1; s0_addr = 32'h600; cyc();
    s0_addr = 32'h604; cyc();
    s0_valid = 0;
    chk("pre_rst_cnt", cnt, 2);
    rst = 1; cyc(); rst = 0;
    settle();
    chk("post_rst_cnt", cnt, 0);
    chk("post_rst_orphan", orphan, 1'b0);
    chk("post_rst_m_valid", m_valid, 1'b0);
    chk("post_rst_s0_rvalid", s0_rvalid, 1'b0);
    chk("post_rst_s1_rvalid", s1_rvalid, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
